// File: rtl/clk_div_period_meter_if.sv
// Bus between the period meter and its user: the waveform and clear go in, measurement results come out.
interface clk_div_period_meter_if #(
   parameter int unsigned CNT_W = 16
);
   logic             clr;
   logic             div_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   modport master (output clr, div_in,
                   input  period, high_time, meas_valid, locked, timeout);
   modport slave  (input  clr, div_in,
                   output period, high_time, meas_valid, locked, timeout);
endinterface

// File: rtl/clk_div_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of an asynchronous square wave in clk cycles,
// and flags lock once consecutive measurements repeat.
module clk_div_period_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_COUNT  = 4
) (
   input  logic                  clk,
   input  logic                  asyn_n_rst,
   clk_div_period_meter_if.slave bus
);
   localparam int unsigned        MATCH_W   = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);

   typedef enum logic [1:0] {SEARCH, HIGH, LOW} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   p_q;
   logic                   s;
   logic                   rise;
   logic                   fall;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic [CNT_W-1:0]       prev_period_q, prev_period_d;
   logic [CNT_W-1:0]       prev_high_q, prev_high_d;
   logic [MATCH_W-1:0]     match_q, match_d;
   logic                   meas_valid_q, meas_valid_d;
   logic                   timeout_q, timeout_d;
   logic                   locked_q, locked_d;

   // Input synchronizer plus one history flop for edge detection
   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst) begin
         sync_q <= '0;
         p_q    <= 1'b0;
      end else if (bus.clr) begin
         sync_q <= '0;
         p_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.div_in};
         p_q    <= s;
      end
   end

   assign s       = sync_q[SYNC_STAGES-1];
   assign rise    = s & ~p_q;
   assign fall    = ~s & p_q;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst) begin
         state_q       <= SEARCH;
         cnt_q         <= '0;
         hi_cap_q      <= '0;
         period_q      <= '0;
         high_q        <= '0;
         prev_period_q <= '0;
         prev_high_q   <= '0;
         match_q       <= '0;
         meas_valid_q  <= 1'b0;
         timeout_q     <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hi_cap_q      <= hi_cap_d;
         period_q      <= period_d;
         high_q        <= high_d;
         prev_period_q <= prev_period_d;
         prev_high_q   <= prev_high_d;
         match_q       <= match_d;
         meas_valid_q  <= meas_valid_d;
         timeout_q     <= timeout_d;
         locked_q      <= locked_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hi_cap_d      = hi_cap_q;
      period_d      = period_q;
      high_d        = high_q;
      prev_period_d = prev_period_q;
      prev_high_d   = prev_high_q;
      match_d       = match_q;
      meas_valid_d  = 1'b0;
      timeout_d     = 1'b0;
      locked_d      = locked_q;

      // Match tracking runs on the cycle the new pair is presented
      if (meas_valid_q) begin
         if ((match_q != '0) && (period_q == prev_period_q) && (high_q == prev_high_q)) begin
            match_d = (match_q >= MATCH_MAX) ? MATCH_MAX : match_q + MATCH_W'(1);
         end else begin
            match_d  = MATCH_W'(1);
            locked_d = 1'b0;
         end
         prev_period_d = period_q;
         prev_high_d   = high_q;
      end else if (match_q == MATCH_MAX) begin
         locked_d = 1'b1;
      end

      case (state_q)
         SEARCH: begin
            if (rise) begin
               cnt_d   = CNT_W'(1);
               state_d = HIGH;
            end
         end
         HIGH: begin
            cnt_d = cnt_inc;
            if (fall) begin
               hi_cap_d = cnt_q;
               state_d  = LOW;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
               state_d   = SEARCH;
            end
         end
         LOW: begin
            if (rise) begin
               period_d     = cnt_q;
               high_d       = hi_cap_q;
               meas_valid_d = 1'b1;
               cnt_d        = CNT_W'(1);
               state_d      = HIGH;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
               state_d   = SEARCH;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = SEARCH;
      endcase

      // Clear wins over everything and mirrors the reset image
      if (bus.clr) begin
         state_d       = SEARCH;
         cnt_d         = '0;
         hi_cap_d      = '0;
         period_d      = '0;
         high_d        = '0;
         prev_period_d = '0;
         prev_high_d   = '0;
         match_d       = '0;
         meas_valid_d  = 1'b0;
         timeout_d     = 1'b0;
         locked_d      = 1'b0;
      end
   end

   assign bus.period     = period_q;
   assign bus.high_time  = high_q;
   assign bus.meas_valid = meas_valid_q;
   assign bus.timeout    = timeout_q;
   assign bus.locked     = locked_q;
endmodule

// File: tb/tb_clk_div_period_meter.sv
// Scoreboard bench for clk_div_period_meter: a 16-bit instance for measurement/lock/reset/clear
// and a 4-bit instance for counter saturation.
module tb_clk_div_period_meter;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CNT4_W = 4;

   typedef struct packed {
      logic [15:0] per;
      logic [15:0] hi;
   } exp_t;

   logic clk = 1'b0;
   logic asyn_n_rst;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   exp_t q4[$];
   exp_t mon_e;
   bit   have_prev = 0;
   int   prev_h = 0;
   int   prev_l = 0;

   always #5 clk = ~clk;

   clk_div_period_meter_if #(.CNT_W(CNT_W))  bus ();
   clk_div_period_meter_if #(.CNT_W(CNT4_W)) bus4 ();

   clk_div_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
      .clk(clk), .asyn_n_rst(asyn_n_rst), .bus(bus.slave));

   clk_div_period_meter #(.CNT_W(CNT4_W), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut4 (
      .clk(clk), .asyn_n_rst(asyn_n_rst), .bus(bus4.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop and compare on every presented measurement
   always @(negedge clk) begin
      if (bus.meas_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL meas_unexpected: got period=%0d high_time=%0d want none at %0t",
                     bus.period, bus.high_time, $time);
         end else begin
            mon_e = q.pop_front();
            check("meas_period", 32'(bus.period), 32'(mon_e.per));
            check("meas_high_time", 32'(bus.high_time), 32'(mon_e.hi));
         end
      end
      if (bus4.meas_valid === 1'b1) begin
         if (q4.size() == 0) begin
            total++; bad++;
            $display("FAIL meas4_unexpected: got period=%0d high_time=%0d want none at %0t",
                     bus4.period, bus4.high_time, $time);
         end else begin
            mon_e = q4.pop_front();
            check("meas4_period", 32'(bus4.period), 32'(mon_e.per));
            check("meas4_high_time", 32'(bus4.high_time), 32'(mon_e.hi));
         end
      end
      if (bus.timeout === 1'b1) begin
         total++; bad++;
         $display("FAIL main_timeout: got 1 want 0 at %0t", $time);
      end
   end

   // One period of h cycles high then l cycles low; its rise completes the previous period
   task automatic drive_period(input int h, input int l);
      if (have_prev) q.push_back({16'(prev_h + prev_l), 16'(prev_h)});
      have_prev = 1;
      prev_h    = h;
      prev_l    = l;
      bus.div_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.div_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr();
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr   = 1'b0;
      have_prev = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish by 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      asyn_n_rst  = 1'b1;
      bus.clr     = 1'b0;
      bus.div_in  = 1'b0;
      bus4.clr    = 1'b0;
      bus4.div_in = 1'b0;
      #1 asyn_n_rst = 1'b0;
      #2;
      check("rst_period", 32'(bus.period), 0);
      check("rst_high_time", 32'(bus.high_time), 0);
      check("rst_meas_valid", 32'(bus.meas_valid), 0);
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_timeout", 32'(bus.timeout), 0);
      idle(2);
      asyn_n_rst = 1'b1;
      idle(2);

      // Divide-by-2 source
      for (int i = 0; i < 8; i++) drive_period(1, 1);
      idle(4);
      check("div2_locked", 32'(bus.locked), 1);

      // Clear while locked
      do_clr();
      check("clr_locked", 32'(bus.locked), 0);
      check("clr_period", 32'(bus.period), 0);
      check("clr_high_time", 32'(bus.high_time), 0);
      check("clr_meas_valid", 32'(bus.meas_valid), 0);
      idle(2);

      // 10 high / 6 low, glitch period 12/4, then relock
      for (int i = 0; i < 6; i++) drive_period(10, 6);
      check("p16_locked", 32'(bus.locked), 1);
      drive_period(12, 4);
      drive_period(10, 6);
      check("glitch_unlocked", 32'(bus.locked), 0);
      for (int i = 0; i < 3; i++) drive_period(10, 6);
      check("relock_pending", 32'(bus.locked), 0);
      drive_period(10, 6);
      check("relocked", 32'(bus.locked), 1);

      // Asynchronous reset in the low phase
      drive_period(10, 3);
      @(posedge clk);
      #2 asyn_n_rst = 1'b0;
      #1;
      check("arst_period", 32'(bus.period), 0);
      check("arst_high_time", 32'(bus.high_time), 0);
      check("arst_locked", 32'(bus.locked), 0);
      check("arst_meas_valid", 32'(bus.meas_valid), 0);
      #1 asyn_n_rst = 1'b1;
      @(negedge clk);
      have_prev = 0;
      idle(3);
      for (int i = 0; i < 3; i++) drive_period(10, 6);
      idle(3);
      check("arst_not_locked", 32'(bus.locked), 0);

      // Short high, long low
      do_clr();
      for (int i = 0; i < 3; i++) drive_period(3, 7);
      idle(3);

      // 4-bit counter saturation
      bus4.div_in = 1'b1;
      idle(3);
      bus4.div_in = 1'b0;
      idle(2);
      q4.push_back({16'd5, 16'd3});
      bus4.div_in = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (bus4.timeout === 1'b1) found = 1;
      end
      check("to4_seen", 32'(found), 1);
      check("to4_period_hold", 32'(bus4.period), 5);
      check("to4_high_hold", 32'(bus4.high_time), 3);
      check("to4_locked", 32'(bus4.locked), 0);
      @(negedge clk);
      check("to4_one_cycle", 32'(bus4.timeout), 0);
      // Falling then rising after timeout restarts from SEARCH
      bus4.div_in = 1'b0;
      idle(3);
      bus4.div_in = 1'b1;
      idle(2);
      bus4.div_in = 1'b0;
      idle(2);
      q4.push_back({16'd4, 16'd2});
      bus4.div_in = 1'b1;
      idle(2);
      bus4.div_in = 1'b0;
      idle(2);
      bus4.clr = 1'b1;
      @(negedge clk);
      bus4.clr = 1'b0;
      check("clr4_timeout", 32'(bus4.timeout), 0);
      check("clr4_period", 32'(bus4.period), 0);

      idle(5);
      check("q_drained", 32'(q.size()), 0);
      check("q4_drained", 32'(q4.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/clk_div_period_meter.md
CLK_DIV_PERIOD_METER -- requirements
Module: clk_div_period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle counter and of the period/high_time outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on div_in (minimum 2).
REQ-003 Parameter LOCK_COUNT, default 4: number of consecutive identical measurements needed to assert locked.
REQ-004 clk  input  1  The only clock; all state updates on posedge clk.
REQ-005 asyn_n_rst  input  1  Asynchronous, active-low reset.
REQ-006 clr  input  1  Synchronous clear; same effect as reset, applied at the next posedge clk.
REQ-007 div_in  input  1  Divided clock or square wave to be measured; may be asynchronous to clk.
REQ-008 period  output  CNT_W  Last measured rise-to-rise period, in clk cycles.
REQ-009 high_time  output  CNT_W  Last measured rise-to-fall time, in clk cycles.
REQ-010 meas_valid  output  1  One-cycle pulse that marks an update of period and high_time.
REQ-011 locked  output  1  High while the last LOCK_COUNT measurements are identical.
REQ-012 timeout  output  1  One-cycle pulse when the counter saturates without an expected edge.

Function
REQ-013 div_in shall pass through SYNC_STAGES flops to produce s; a further flop shall hold p (the previous value of s).
REQ-014 rise = s & ~p; fall = ~s & p; both are single-cycle signals.
REQ-015 The FSM shall have three states: SEARCH, HIGH and LOW. The reset state is SEARCH.
REQ-016 SEARCH: fall is ignored. On rise, load cnt <= 1 and go to HIGH.
REQ-017 HIGH: cnt <= cnt+1 on every cycle, including the cycle where fall occurs. On fall, capture hi_cap <= cnt (the pre-increment value) and go to LOW.
REQ-018 LOW: on rise, apply all of the following in the same cycle, then go to HIGH:
- period <= cnt
- high_time <= hi_cap
- meas_valid = 1 for exactly that cycle
- cnt <= 1
REQ-019 LOW without rise: cnt <= cnt+1.
REQ-020 The counter shall not wrap. In HIGH or LOW, if cnt equals all-ones and no expected edge occurs this cycle:
- timeout = 1 for one cycle
- locked <= 0
- match count cleared
- go to SEARCH
- period and high_time hold their values
REQ-021 Match logic on each meas_valid:
- If the new (period, high_time) equals the previously captured pair, match_cnt <= min(match_cnt+1, LOCK_COUNT).
- Otherwise, match_cnt <= 1 and locked <= 0.
- The first measurement after SEARCH sets match_cnt <= 1.
REQ-022 locked shall assert in the cycle after match_cnt reaches LOCK_COUNT, and shall stay high until a mismatch, timeout, clr or reset occurs.
REQ-023 A fall in the same cycle as counter saturation in HIGH counts as an edge: capture hi_cap and take no timeout.
REQ-024 A rise in the same cycle as saturation in LOW counts as an edge: take the measurement and take no timeout.
REQ-025 Detection latency: an edge on div_in, once sampled by the first synchronizer flop, produces rise/fall SYNC_STAGES cycles later. Measured values are not affected by this latency.
REQ-026 clr has priority over all FSM activity in its cycle. meas_valid and timeout shall be 0 in the cycle clr is applied.

Reset
REQ-027 When asyn_n_rst = 0, immediately and independently of clk:
- all synchronizer flops and p = 0
- state = SEARCH
- cnt, hi_cap, period, high_time, match_cnt = 0
- meas_valid, locked, timeout = 0
REQ-028 Reset asserted mid-measurement shall discard the partial measurement. After release, no meas_valid shall occur before one full rise-fall-rise sequence.
REQ-029 clr shall produce the same register values as reset, one posedge after it is sampled high.

Verification
REQ-030 div_in toggles on every clk posedge (divide-by-2 source) -> period = 2 and high_time = 1 on every meas_valid; locked rises after the 4th meas_valid.
REQ-031 div_in with 10 cycles high and 6 low, repeated -> period = 16, high_time = 10, meas_valid every 16 cycles, locked = 1 after 4 periods.
REQ-032 Locked on 16/10, then one period of 12 high / 4 low -> meas_valid with period = 16, high_time = 12, locked drops to 0 in the next cycle, and relocks after 3 further matching 16/10 periods.
REQ-033 CNT_W = 4 and div_in held high after a rise -> timeout pulse when cnt = 15, locked = 0, state returns to SEARCH, period and high_time unchanged.
REQ-034 asyn_n_rst pulsed low between clk edges during LOW -> all outputs 0 immediately; the first meas_valid after release follows a complete rise-fall-rise sequence.
REQ-035 clr held high for 1 cycle while locked -> locked = 0, period = 0 and high_time = 0 on the next cycle, and no meas_valid pulse in that cycle.
